exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Initiator side of the CP0 exception interface.
- Watches the instruction retiring from the MEM stage and decides when to raise S_SYSCALL / EPC_IN toward CP0.
- Runs a flush-then-redirect sequence for the fetch stage: to the handler on SYSCALL, to CP0's EPC on ERET.
- Sits between the MEM stage, CP0 and the PC/fetch unit; tracks a single exception-level (EXL) bit.

Parameters:
- HANDLER_ADDR, 32'hBFC0_0380, redirect target on SYSCALL (and BREAK).
- FLUSH_CYCLES, 2, cycles FLUSH is held before redirect; legal range 1..15.

Ports:
- CLK  input  1  clock
- RESETN  input  1  reset; asynchronous, active-low
- PIPELINE_READY  input  1  pipeline advances this cycle; shared with CP0
- MEM_VALID  input  1  MEM-stage slot holds a real instruction
- MEM_PC  input  32  PC of the MEM-stage instruction
- MEM_SYSCALL  input  1  MEM instruction is SYSCALL
- MEM_ERET  input  1  MEM instruction is ERET
- EPC  input  32  current EPC from CP0
- S_SYSCALL  output  1  to CP0: capture EPC_IN this cycle
- EPC_IN  output  32  to CP0: PC to save
- FLUSH  output  1  kill IF/ID/EX/MEM contents
- REDIRECT_VALID  output  1  fetch must load REDIRECT_PC
- REDIRECT_PC  output  32  new fetch address
- EXL  output  1  exception level: 1 while inside the handler
- BUSY  output  1  state != IDLE

Behaviour:
- Reset: asynchronous on RESETN=0. State goes to IDLE; cnt, EXL, redirect target register and all outputs go to 0.
- States:
  - IDLE
  - FLUSH (hold FLUSH=1 for FLUSH_CYCLES cycles)
  - REDIRECT (hold REDIRECT_VALID=1 until accepted)
- accept = IDLE & PIPELINE_READY & MEM_VALID & (MEM_SYSCALL | MEM_ERET). No acceptance outside IDLE; MEM-stage flags are ignored there.
- Priority when several flags are set: SYSCALL > (BREAK) > ERET.
- S_SYSCALL:
  - Combinational: S_SYSCALL = accept & sel==SYSCALL & ~EXL.
  - EPC_IN = MEM_PC at all times, so CP0 captures it at the same clock edge as acceptance.
  - SYSCALL with EXL=1: S_SYSCALL stays 0 (EPC preserved); flush and redirect to HANDLER_ADDR still occur.
- At the acceptance edge:
  - Target register <= HANDLER_ADDR (SYSCALL) or EPC (ERET), sampled that cycle.
  - EXL <= 1 on SYSCALL.
  - cnt <= FLUSH_CYCLES-1; state -> FLUSH.
- FLUSH:
  - FLUSH=1 registered output, high for exactly FLUSH_CYCLES cycles, independent of PIPELINE_READY.
  - cnt decrements each cycle; at cnt==0, go to REDIRECT.
- REDIRECT:
  - REDIRECT_VALID=1 and REDIRECT_PC=target, held stable until a cycle with PIPELINE_READY=1.
  - At that edge: go to IDLE; if the sequence was ERET, EXL <= 0.
  - FLUSH=0 in REDIRECT.
- Latency: acceptance edge T → FLUSH high in T+1..T+FLUSH_CYCLES → REDIRECT_VALID first high in T+FLUSH_CYCLES+1.
- ERET with EXL=0: redirect to EPC anyway; EXL stays 0.
- REDIRECT_PC=0 whenever REDIRECT_VALID=0.
- BUSY=1 in FLUSH and REDIRECT.
- Back-to-back: the earliest next acceptance is the cycle after REDIRECT completes.
- Reset mid-sequence: abort immediately; no redirect is issued and EXL is cleared.

Optional Feature:
- Macro EXC_BREAK_EN.
- Defined:
  - Adds input MEM_BREAK (1 bit) and output EXC_CODE (5 bits, registered).
  - BREAK behaves exactly like SYSCALL (S_SYSCALL, EXL, HANDLER_ADDR target).
  - EXC_CODE is loaded at acceptance: 8 for SYSCALL, 9 for BREAK; it holds until the next SYSCALL/BREAK acceptance and resets to 0.
- Undefined: neither port exists; BREAK is not recognised.

Test Plan:
- Reset then idle: RESETN low 3 cycles, release, MEM_VALID=0 → all outputs 0, EXL=0, BUSY=0 for 10 cycles.
- SYSCALL at MEM_PC=32'h0040_0010, READY=1, FLUSH_CYCLES=2:
  - S_SYSCALL=1 and EPC_IN=32'h0040_0010 in the acceptance cycle.
  - FLUSH high 2 cycles.
  - REDIRECT_VALID=1 with REDIRECT_PC=32'hBFC0_0380.
  - EXL=1.
- ERET with EPC=32'h0040_0014 and EXL=1; READY held 0 for 3 cycles during REDIRECT → REDIRECT_VALID/PC held stable, then drop one cycle after READY=1; EXL=0.
- Nested SYSCALL with EXL=1 → S_SYSCALL stays 0, flush and redirect to HANDLER_ADDR still occur.
- SYSCALL+ERET same cycle → SYSCALL wins. MEM_VALID=0 with SYSCALL=1 → no action.
- RESETN pulsed low in FLUSH → outputs cleared asynchronously, no REDIRECT_VALID afterwards.
- EXC_BREAK_EN defined: BREAK at PC 32'h0040_0020 → EXC_CODE=9, S_SYSCALL=1, EPC_IN=32'h0040_0020.

Source files
------------

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl : initiator side of the CP0 exception interface.
//
// Watches the instruction retiring from the MEM stage. A SYSCALL (or BREAK when
// EXC_BREAK_EN is defined) or an ERET is accepted only while idle. After it is
// accepted, the block flushes IF/ID/EX/MEM for FLUSH_CYCLES cycles. It then
// presents a fetch redirect: to HANDLER_ADDR for a trap, or to CP0's EPC for an
// ERET. It also keeps the exception-level (EXL) bit.
//
// Optional feature macro: EXC_BREAK_EN (adds MEM_BREAK input and EXC_CODE out).
//
// Ports:
//   CLK, RESETN        clock, asynchronous active-low reset
//   PIPELINE_READY     pipeline advances this cycle (shared with CP0)
//   MEM_VALID          MEM-stage slot holds a real instruction
//   MEM_PC             PC of the MEM-stage instruction
//   MEM_SYSCALL        MEM instruction is SYSCALL
//   MEM_ERET           MEM instruction is ERET
//   MEM_BREAK          MEM instruction is BREAK          (EXC_BREAK_EN only)
//   EPC                current EPC from CP0
//   S_SYSCALL          to CP0: capture EPC_IN this cycle (combinational)
//   EPC_IN             to CP0: PC to save (always MEM_PC)
//   FLUSH              kill IF/ID/EX/MEM contents (registered)
//   REDIRECT_VALID     fetch must load REDIRECT_PC (registered)
//   REDIRECT_PC        new fetch address, 0 when not redirecting (registered)
//   EXL                exception level, 1 while inside the handler
//   BUSY               a flush/redirect sequence is in progress
//   EXC_CODE           8 = SYSCALL, 9 = BREAK               (EXC_BREAK_EN only)
// -----------------------------------------------------------------------------
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        PIPELINE_READY,
  input  logic        MEM_VALID,
  input  logic [31:0] MEM_PC,
  input  logic        MEM_SYSCALL,
  input  logic        MEM_ERET,
`ifdef EXC_BREAK_EN
  input  logic        MEM_BREAK,
  output logic [4:0]  EXC_CODE,
`endif
  input  logic [31:0] EPC,
  output logic        S_SYSCALL,
  output logic [31:0] EPC_IN,
  output logic        FLUSH,
  output logic        REDIRECT_VALID,
  output logic [31:0] REDIRECT_PC,
  output logic        EXL,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  // The counter starts at FLUSH_CYCLES-1 so the FLUSH state lasts exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic [31:0] target_r;
  logic        eret_seq_r;
  logic        exl_r;
  logic        flush_r;
  logic        redirect_valid_r;
  logic [31:0] redirect_pc_r;
  logic        busy_r;
  logic        brk_s;
  logic        trap_s;
  logic        accept_s;
  logic        redirect_done_s;

`ifdef EXC_BREAK_EN
  logic [4:0]  exc_code_r;
  assign brk_s    = MEM_BREAK;
  assign EXC_CODE = exc_code_r;
`else
  assign brk_s    = 1'b0;
`endif

  // SYSCALL and BREAK take the same path, and both win over ERET in the same slot.
  assign trap_s          = MEM_SYSCALL | brk_s;
  assign accept_s        = (state_r == ST_IDLE) & PIPELINE_READY & MEM_VALID & (trap_s | MEM_ERET);
  assign redirect_done_s = (state_r == ST_REDIRECT) & PIPELINE_READY;

  // If a trap nests inside the handler (EXL already set), S_SYSCALL stays low so the saved EPC is kept.
  assign S_SYSCALL      = accept_s & trap_s & ~exl_r;
  assign EPC_IN         = MEM_PC;
  assign FLUSH          = flush_r;
  assign REDIRECT_VALID = redirect_valid_r;
  assign REDIRECT_PC    = redirect_pc_r;
  assign EXL            = exl_r;
  assign BUSY           = busy_r;

  // Next-state and flush-counter logic for the flush-then-redirect sequence.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_FLUSH;
          cnt_nxt_s   = CNT_INIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_REDIRECT;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_REDIRECT: begin
        if (PIPELINE_READY) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REDIRECT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and sequence bookkeeping (target address, sequence kind).
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      target_r   <= 32'd0;
      eret_seq_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        // EPC is sampled at acceptance, so later CP0 updates do not move the ERET target.
        target_r   <= trap_s ? HANDLER_ADDR : EPC;
        eret_seq_r <= ~trap_s;
      end
    end
  end

  // Exception level: set on trap acceptance, cleared when an ERET redirect completes.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      exl_r <= 1'b0;
    end else if (accept_s && trap_s) begin
      exl_r <= 1'b1;
    end else if (redirect_done_s && eret_seq_r) begin
      exl_r <= 1'b0;
    end
  end

  // Registered outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
      busy_r           <= 1'b0;
    end else begin
      flush_r          <= (state_nxt_s == ST_FLUSH);
      redirect_valid_r <= (state_nxt_s == ST_REDIRECT);
      redirect_pc_r    <= (state_nxt_s == ST_REDIRECT) ? target_r : 32'd0;
      busy_r           <= (state_nxt_s != ST_IDLE);
    end
  end

`ifdef EXC_BREAK_EN
  // Exception code is loaded on each trap acceptance; SYSCALL wins over BREAK.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      exc_code_r <= 5'd0;
    end else if (accept_s && trap_s) begin
      exc_code_r <= MEM_SYSCALL ? 5'd8 : 5'd9;
    end
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
  localparam int          FC    = 2;
  localparam logic [31:0] HADDR = 32'hBFC0_0380;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        PIPELINE_READY = 1'b0;
  logic        MEM_VALID = 1'b0;
  logic [31:0] MEM_PC = 32'd0;
  logic        MEM_SYSCALL = 1'b0;
  logic        MEM_ERET = 1'b0;
  logic [31:0] EPC = 32'd0;
  logic        S_SYSCALL;
  logic [31:0] EPC_IN;
  logic        FLUSH;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic        EXL;
  logic        BUSY;
`ifdef EXC_BREAK_EN
  logic        MEM_BREAK = 1'b0;
  logic [4:0]  EXC_CODE;
`endif

  // {FLUSH, REDIRECT_VALID, EXL, BUSY}
  wire [3:0] st = {FLUSH, REDIRECT_VALID, EXL, BUSY};

  int n_cmp  = 0;
  int n_fail = 0;

  exc_ctrl #(.HANDLER_ADDR(HADDR), .FLUSH_CYCLES(FC)) dut (
    .CLK(CLK), .RESETN(RESETN), .PIPELINE_READY(PIPELINE_READY),
    .MEM_VALID(MEM_VALID), .MEM_PC(MEM_PC), .MEM_SYSCALL(MEM_SYSCALL),
    .MEM_ERET(MEM_ERET),
`ifdef EXC_BREAK_EN
    .MEM_BREAK(MEM_BREAK), .EXC_CODE(EXC_CODE),
`endif
    .EPC(EPC), .S_SYSCALL(S_SYSCALL), .EPC_IN(EPC_IN), .FLUSH(FLUSH),
    .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .EXL(EXL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    MEM_VALID   = 1'b0;
    MEM_SYSCALL = 1'b0;
    MEM_ERET    = 1'b0;
`ifdef EXC_BREAK_EN
    MEM_BREAK   = 1'b0;
`endif
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    idle_in();
    PIPELINE_READY = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if ({st, S_SYSCALL} !== 5'b0 || REDIRECT_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: st=%b ss=%b rpc=%h want all 0", st, S_SYSCALL, REDIRECT_PC);
    end
    RESETN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if ({st, S_SYSCALL} !== 5'b0 || REDIRECT_PC !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: st=%b ss=%b rpc=%h want all 0", i, st, S_SYSCALL, REDIRECT_PC);
      end
    end
  endtask

  task automatic test_syscall();
    MEM_VALID = 1'b1; MEM_SYSCALL = 1'b1; MEM_PC = 32'h0040_0010; PIPELINE_READY = 1'b1;
    #1;
    n_cmp++;
    if (S_SYSCALL !== 1'b1 || EPC_IN !== 32'h0040_0010) begin
      n_fail++;
      $display("FAIL sys_accept: ss=%b epc_in=%h want 1 00400010", S_SYSCALL, EPC_IN);
    end
    cyc(); idle_in();
    n_cmp++;
    if (st !== 4'b1011 || REDIRECT_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL sys_flush1: st=%b rpc=%h want 1011 0", st, REDIRECT_PC);
    end
    cyc();
    n_cmp++;
    if (st !== 4'b1011) begin
      n_fail++;
      $display("FAIL sys_flush2: st=%b want 1011", st);
    end
    cyc();
    n_cmp++;
    if (st !== 4'b0111 || REDIRECT_PC !== HADDR) begin
      n_fail++;
      $display("FAIL sys_redirect: st=%b rpc=%h want 0111 %h", st, REDIRECT_PC, HADDR);
    end
    cyc();
    n_cmp++;
    if (st !== 4'b0010 || REDIRECT_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL sys_done: st=%b rpc=%h want 0010 0", st, REDIRECT_PC);
    end
  endtask

  task automatic test_eret_stall();
    MEM_VALID = 1'b1; MEM_ERET = 1'b1; MEM_PC = 32'h0040_0030; EPC = 32'h0040_0014; PIPELINE_READY = 1'b1;
    #1;
    n_cmp++;
    if (S_SYSCALL !== 1'b0) begin
      n_fail++;
      $display("FAIL eret_ss: ss=%b want 0", S_SYSCALL);
    end
    cyc(); idle_in(); PIPELINE_READY = 1'b0; EPC = 32'hDEAD_BEEF;
    n_cmp++;
    if (st !== 4'b1011) begin
      n_fail++;
      $display("FAIL eret_flush1: st=%b want 1011", st);
    end
    cyc();
    n_cmp++;
    if (st !== 4'b1011) begin
      n_fail++;
      $display("FAIL eret_flush2: st=%b want 1011", st);
    end
    cyc();
    n_cmp++;
    if (st !== 4'b0111 || REDIRECT_PC !== 32'h0040_0014) begin
      n_fail++;
      $display("FAIL eret_redirect0: st=%b rpc=%h want 0111 00400014", st, REDIRECT_PC);
    end
    for (int i = 1; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (st !== 4'b0111 || REDIRECT_PC !== 32'h0040_0014) begin
        n_fail++;
        $display("FAIL eret_stall[%0d]: st=%b rpc=%h want 0111 00400014", i, st, REDIRECT_PC);
      end
    end
    PIPELINE_READY = 1'b1;
    #1;
    n_cmp++;
    if (st !== 4'b0111) begin
      n_fail++;
      $display("FAIL eret_ready_same: st=%b want 0111", st);
    end
    cyc();
    n_cmp++;
    if (st !== 4'b0000 || REDIRECT_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL eret_done: st=%b rpc=%h want 0000 0", st, REDIRECT_PC);
    end
  endtask

  task automatic test_nested();
    MEM_VALID = 1'b1; MEM_SYSCALL = 1'b1; MEM_PC = 32'h0040_0040; PIPELINE_READY = 1'b1;
    #1;
    n_cmp++;
    if (S_SYSCALL !== 1'b1) begin
      n_fail++;
      $display("FAIL nest_first_ss: ss=%b want 1", S_SYSCALL);
    end
    cyc(); idle_in();
    repeat (FC) cyc();
    cyc();
    n_cmp++;
    if (st !== 4'b0010) begin
      n_fail++;
      $display("FAIL nest_first_done: st=%b want 0010", st);
    end
    MEM_VALID = 1'b1; MEM_SYSCALL = 1'b1; MEM_PC = 32'h0040_0050;
    #1;
    n_cmp++;
    if (S_SYSCALL !== 1'b0 || EPC_IN !== 32'h0040_0050) begin
      n_fail++;
      $display("FAIL nest_ss: ss=%b epc_in=%h want 0 00400050", S_SYSCALL, EPC_IN);
    end
    cyc(); idle_in();
    n_cmp++;
    if (st !== 4'b1011) begin
      n_fail++;
      $display("FAIL nest_flush: st=%b want 1011", st);
    end
    cyc(); cyc();
    n_cmp++;
    if (st !== 4'b0111 || REDIRECT_PC !== HADDR) begin
      n_fail++;
      $display("FAIL nest_redirect: st=%b rpc=%h want 0111 %h", st, REDIRECT_PC, HADDR);
    end
    cyc();
    n_cmp++;
    if (st !== 4'b0010) begin
      n_fail++;
      $display("FAIL nest_done: st=%b want 0010", st);
    end
    MEM_VALID = 1'b1; MEM_ERET = 1'b1; EPC = 32'h0040_0060;
    cyc(); idle_in();
    repeat (FC) cyc();
    n_cmp++;
    if (st !== 4'b0111 || REDIRECT_PC !== 32'h0040_0060) begin
      n_fail++;
      $display("FAIL nest_eret_redirect: st=%b rpc=%h want 0111 00400060", st, REDIRECT_PC);
    end
    cyc();
    n_cmp++;
    if (st !== 4'b0000) begin
      n_fail++;
      $display("FAIL nest_eret_done: st=%b want 0000", st);
    end
  endtask

  task automatic test_priority();
    MEM_VALID = 1'b1; MEM_SYSCALL = 1'b1; MEM_ERET = 1'b1; EPC = 32'h0040_0070; MEM_PC = 32'h0040_0080;
    PIPELINE_READY = 1'b1;
    #1;
    n_cmp++;
    if (S_SYSCALL !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_ss: ss=%b want 1", S_SYSCALL);
    end
    cyc(); idle_in();
    n_cmp++;
    if (st !== 4'b1011) begin
      n_fail++;
      $display("FAIL prio_flush: st=%b want 1011", st);
    end
    MEM_VALID = 1'b1; MEM_SYSCALL = 1'b1;
    #1;
    n_cmp++;
    if (S_SYSCALL !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_ss: ss=%b want 0", S_SYSCALL);
    end
    cyc(); cyc();
    n_cmp++;
    if (st !== 4'b0111 || REDIRECT_PC !== HADDR) begin
      n_fail++;
      $display("FAIL prio_redirect: st=%b rpc=%h want 0111 %h", st, REDIRECT_PC, HADDR);
    end
    idle_in();
    cyc();
    n_cmp++;
    if (st !== 4'b0010) begin
      n_fail++;
      $display("FAIL prio_done: st=%b want 0010", st);
    end
    MEM_VALID = 1'b1; MEM_ERET = 1'b1; EPC = 32'h0040_0090;
    cyc(); idle_in();
    repeat (FC) cyc();
    cyc();
    n_cmp++;
    if (st !== 4'b0000) begin
      n_fail++;
      $display("FAIL prio_eret_done: st=%b want 0000", st);
    end
    MEM_VALID = 1'b0; MEM_SYSCALL = 1'b1;
    #1;
    n_cmp++;
    if (S_SYSCALL !== 1'b0) begin
      n_fail++;
      $display("FAIL novalid_ss: ss=%b want 0", S_SYSCALL);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++;
      if (st !== 4'b0000) begin
        n_fail++;
        $display("FAIL novalid_idle[%0d]: st=%b want 0000", i, st);
      end
    end
    idle_in();
  endtask

  task automatic test_reset_mid();
    MEM_VALID = 1'b1; MEM_SYSCALL = 1'b1; MEM_PC = 32'h0040_00A0; PIPELINE_READY = 1'b1;
    cyc(); idle_in();
    n_cmp++;
    if (st !== 4'b1011) begin
      n_fail++;
      $display("FAIL rstmid_flush: st=%b want 1011", st);
    end
    #2 RESETN = 1'b0;
    #1;
    n_cmp++;
    if (st !== 4'b0000 || REDIRECT_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: st=%b rpc=%h want 0000 0", st, REDIRECT_PC);
    end
    cyc();
    RESETN = 1'b1;
    for (int i = 0; i < 2 * FC + 4; i++) begin
      cyc();
      n_cmp++;
      if (st !== 4'b0000 || REDIRECT_PC !== 32'h0) begin
        n_fail++;
        $display("FAIL rstmid_after[%0d]: st=%b rpc=%h want 0000 0", i, st, REDIRECT_PC);
      end
    end
  endtask

`ifdef EXC_BREAK_EN
  task automatic test_break();
    MEM_VALID = 1'b1; MEM_BREAK = 1'b1; MEM_PC = 32'h0040_0020; PIPELINE_READY = 1'b1;
    #1;
    n_cmp++;
    if (S_SYSCALL !== 1'b1 || EPC_IN !== 32'h0040_0020) begin
      n_fail++;
      $display("FAIL brk_accept: ss=%b epc_in=%h want 1 00400020", S_SYSCALL, EPC_IN);
    end
    cyc(); idle_in();
    n_cmp++;
    if (EXC_CODE !== 5'd9 || st !== 4'b1011) begin
      n_fail++;
      $display("FAIL brk_code: code=%0d st=%b want 9 1011", EXC_CODE, st);
    end
    repeat (FC) cyc();
    n_cmp++;
    if (REDIRECT_PC !== HADDR) begin
      n_fail++;
      $display("FAIL brk_redirect: rpc=%h want %h", REDIRECT_PC, HADDR);
    end
    cyc();
    MEM_VALID = 1'b1; MEM_ERET = 1'b1; EPC = 32'h0040_0024;
    cyc(); idle_in();
    repeat (FC) cyc();
    cyc();
  endtask
`endif

  // Random traffic against a timeline model: each sequence is described by the
  // number of cycles elapsed since its acceptance edge.
  task automatic test_random();
    bit          m_busy = 1'b0;
    int          m_t = 0;
    bit          m_exl = 1'b0;
    bit          m_is_eret = 1'b0;
    logic [31:0] m_target = 32'd0;
    bit          e_flush, e_redir, trap, acc, brk;
`ifdef EXC_BREAK_EN
    logic [4:0]  m_code = 5'd0;
`endif
    RESETN = 1'b0; idle_in();
    cyc(); cyc();
    RESETN = 1'b1;
    for (int i = 0; i < 400; i++) begin
      MEM_VALID      = ($urandom_range(0, 3) != 0);
      MEM_SYSCALL    = ($urandom_range(0, 2) == 0);
      MEM_ERET       = ($urandom_range(0, 2) == 0);
      PIPELINE_READY = ($urandom_range(0, 3) != 0);
      MEM_PC         = $urandom;
      EPC            = $urandom;
      brk            = 1'b0;
`ifdef EXC_BREAK_EN
      MEM_BREAK      = ($urandom_range(0, 3) == 0);
      brk            = MEM_BREAK;
`endif
      #1;
      e_flush = m_busy && (m_t <= FC);
      e_redir = m_busy && (m_t > FC);
      trap    = MEM_SYSCALL || brk;
      acc     = !m_busy && PIPELINE_READY && MEM_VALID && (trap || MEM_ERET);
      n_cmp++;
      if (S_SYSCALL !== (acc && trap && !m_exl) || EPC_IN !== MEM_PC) begin
        n_fail++;
        $display("FAIL rnd_cp0[%0d]: ss=%b epc_in=%h want %b %h", i, S_SYSCALL, EPC_IN, acc && trap && !m_exl, MEM_PC);
      end
      n_cmp++;
      if (st !== {e_flush, e_redir, m_exl, m_busy} || REDIRECT_PC !== (e_redir ? m_target : 32'd0)) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: st=%b rpc=%h want %b %h", i, st, REDIRECT_PC,
                 {e_flush, e_redir, m_exl, m_busy}, e_redir ? m_target : 32'd0);
      end
`ifdef EXC_BREAK_EN
      n_cmp++;
      if (EXC_CODE !== m_code) begin
        n_fail++;
        $display("FAIL rnd_code[%0d]: code=%0d want %0d", i, EXC_CODE, m_code);
      end
`endif
      if (acc) begin
        m_busy    = 1'b1;
        m_t       = 1;
        m_target  = trap ? HADDR : EPC;
        m_is_eret = !trap;
        if (trap) m_exl = 1'b1;
`ifdef EXC_BREAK_EN
        if (trap) m_code = MEM_SYSCALL ? 5'd8 : 5'd9;
`endif
      end else if (m_busy) begin
        if (e_redir && PIPELINE_READY) begin
          m_busy = 1'b0;
          if (m_is_eret) m_exl = 1'b0;
        end else begin
          m_t++;
        end
      end
      cyc();
    end
    idle_in();
  endtask

  initial begin
    #1;
    test_reset();
    test_syscall();
    test_eret_stall();
    test_nested();
    test_priority();
    test_reset_mid();
`ifdef EXC_BREAK_EN
    test_break();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1, "timeout");
  end

endmodule
